// File: rtl/axi_lite_rr_arbiter.sv
// Two-port round-robin arbiter that serialises single-beat reads/writes onto one
// AXI-Lite slave, with a per-state watchdog that aborts stalled transactions.
module axi_lite_rr_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

   state_t                state, state_nxt;
   logic                  last, owner, win, any_req;
   logic [ADDR_WIDTH-1:0] cap_addr, sel_addr;
   logic [DATA_WIDTH-1:0] cap_wdata, sel_wdata;
   logic                  aw_done, w_done, aw_hs, w_hs;
   logic [CW-1:0]         wd_cnt;
   logic                  wd_hit, abort, in_wait;

   assign any_req   = |req_valid;
   // Contention goes to whoever was not served last; a lone requester always wins.
   assign win       = (req_valid == 2'b11) ? ~last : req_valid[1];
   assign sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
   assign sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign in_wait = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

   generate
      if (TIMEOUT == 0) begin : g_no_wd
         assign wd_hit = 1'b0;
      end else begin : g_wd
         assign wd_hit = (wd_cnt == CW'(TIMEOUT - 1));
      end
   endgenerate

   always_ff @(posedge aclk) begin
      if (!areset_n) state <= IDLE;
      else           state <= state_nxt;
   end

   // Normal exits are tested before the watchdog so a same-cycle completion wins.
   always_comb begin
      state_nxt = state;
      abort     = 1'b0;
      case (state)
         IDLE:    if (any_req) state_nxt = req_write[win] ? WR_REQ : RD_REQ;
         WR_REQ:  if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
                  else if (wd_hit) begin state_nxt = DONE; abort = 1'b1; end
         WR_RESP: if (BVALID) state_nxt = DONE;
                  else if (wd_hit) begin state_nxt = DONE; abort = 1'b1; end
         RD_REQ:  if (ARREADY) state_nxt = RD_RESP;
                  else if (wd_hit) begin state_nxt = DONE; abort = 1'b1; end
         RD_RESP: if (RVALID) state_nxt = DONE;
                  else if (wd_hit) begin state_nxt = DONE; abort = 1'b1; end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      if (state == IDLE && any_req) req_ready = win ? 2'b10 : 2'b01;
      if (state == DONE)            rsp_valid = owner ? 2'b10 : 2'b01;
      AWVALID = (state == WR_REQ) && !aw_done;
      WVALID  = (state == WR_REQ) && !w_done;
      BREADY  = (state == WR_RESP);
      ARVALID = (state == RD_REQ);
      RREADY  = (state == RD_RESP);
   end

   assign AWADDR = cap_addr;
   assign ARADDR = cap_addr;
   assign WDATA  = cap_wdata;
   assign WSTRB  = '1;

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         last      <= 1'b1;
         owner     <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
         wd_cnt    <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            last      <= win;
            owner     <= win;
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
         end
         if (state == WR_REQ) begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
         end
         if (abort) begin
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
         end else if (state == WR_RESP && BVALID) begin
            rsp_rdata <= '0;
            rsp_resp  <= BRESP;
         end else if (state == RD_RESP && RVALID) begin
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
         end
         if (state_nxt != state) wd_cnt <= '0;
         else if (in_wait)       wd_cnt <= wd_cnt + 1'b1;
      end
   end

endmodule
